// File: rtl/wb_stage_if.sv
// wb_stage_if: bundles the M-stage capture inputs, the hazard controls and the
// W-stage outputs of the MEM/WB pipeline register.
//   master modport : M stage / hazard unit side (drives m_*, stall, flush)
//   slave modport  : wb_stage side (drives w_*)
interface wb_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
);
    // Hazard control
    logic              stall;
    logic              flush;

    // M-stage payload
    logic              m_valid;
    logic [1:0]        m_sel;
    logic [DATA_W-1:0] m_alu;
    logic [DATA_W-1:0] m_mem;
    logic [DATA_W-1:0] m_md;
    logic [DATA_W-1:0] m_pc;
    logic              m_we;
    logic [REG_AW-1:0] m_wa;
    logic [1:0]        m_addr_lo;
    logic [2:0]        m_ld_type;

    // W-stage results
    logic              w_valid;
    logic              w_we;
    logic [REG_AW-1:0] w_wa;
    logic [DATA_W-1:0] w_wd;
    logic [DATA_W-1:0] w_pc;
    logic [CNT_W-1:0]  w_retired;

    modport master (
        output stall, flush,
        output m_valid, m_sel, m_alu, m_mem, m_md, m_pc,
        output m_we, m_wa, m_addr_lo, m_ld_type,
        input  w_valid, w_we, w_wa, w_wd, w_pc, w_retired
    );

    modport slave (
        input  stall, flush,
        input  m_valid, m_sel, m_alu, m_mem, m_md, m_pc,
        input  m_we, m_wa, m_addr_lo, m_ld_type,
        output w_valid, w_we, w_wa, w_wd, w_pc, w_retired
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back data selector.
// Selects the write-back value from ALU / memory / PC+8 / HI-LO, optionally
// sign/zero-extends sub-word loads, qualifies the GRF write enable and counts
// retired instructions. All outputs are registered (1-cycle latency).
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high; clears every output to 0
//   wb    - wb_stage_if.slave: stall/flush, m_* inputs, w_* outputs
// Configuration macro: WB_LOAD_EXT_EN enables lb/lbu/lh/lhu extension; when
// undefined the memory word is written back unchanged.
module wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic        clk,
    input  logic        reset,
    wb_stage_if.slave   wb
);

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC8 = 2'b10;

    logic [DATA_W-1:0] memData;
    logic [DATA_W-1:0] pcPlus8;
    logic [DATA_W-1:0] selData;
    logic              weQual;

`ifdef WB_LOAD_EXT_EN
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    // Sub-word pick and extension; unknown load types behave as lw
    always_comb begin
        ldByte = 8'h00;
        case (wb.m_addr_lo)
            2'd0:    ldByte = wb.m_mem[7:0];
            2'd1:    ldByte = wb.m_mem[15:8];
            2'd2:    ldByte = wb.m_mem[23:16];
            default: ldByte = wb.m_mem[31:24];
        endcase
        ldHalf = wb.m_addr_lo[1] ? wb.m_mem[31:16] : wb.m_mem[15:0];

        memData = wb.m_mem;
        case (wb.m_ld_type)
            LD_LB:   memData = {{(DATA_W-8){ldByte[7]}}, ldByte};
            LD_LBU:  memData = DATA_W'(ldByte);
            LD_LH:   memData = {{(DATA_W-16){ldHalf[15]}}, ldHalf};
            LD_LHU:  memData = DATA_W'(ldHalf);
            default: memData = wb.m_mem;
        endcase
    end
`else
    // Without extension the load type and byte offset have no effect
    logic unusedLdBits;
    assign unusedLdBits = ^{wb.m_ld_type, wb.m_addr_lo};

    always_comb begin
        memData = wb.m_mem;
    end
`endif

    // Write-back source select and write-enable qualification
    always_comb begin
        pcPlus8 = wb.m_pc + DATA_W'(8);
        selData = wb.m_md;
        case (wb.m_sel)
            SEL_ALU: selData = wb.m_alu;
            SEL_MEM: selData = memData;
            SEL_PC8: selData = pcPlus8;
            default: selData = wb.m_md;
        endcase
        weQual = wb.m_we & wb.m_valid & (wb.m_wa != '0);
    end

    // W register: reset > flush > stall > load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb.w_valid   <= 1'b0;
            wb.w_we      <= 1'b0;
            wb.w_wa      <= '0;
            wb.w_wd      <= '0;
            wb.w_pc      <= '0;
            wb.w_retired <= '0;
        end else if (wb.flush) begin
            wb.w_valid <= 1'b0;
            wb.w_we    <= 1'b0;
            wb.w_wa    <= '0;
            wb.w_wd    <= '0;
            wb.w_pc    <= '0;
        end else if (!wb.stall) begin
            wb.w_valid <= wb.m_valid;
            wb.w_we    <= weQual;
            wb.w_wa    <= wb.m_wa;
            wb.w_wd    <= selData;
            wb.w_pc    <= wb.m_pc;
            if (wb.m_valid) begin
                wb.w_retired <= wb.w_retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;

    logic clk;
    logic reset;

    wb_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) wbIf ();

    wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wbIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checkCnt = 0;
    int          errCnt   = 0;
    logic [31:0] expRet   = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".valid"},   32'(wbIf.w_valid), 32'd0);
        check({tag, ".we"},      32'(wbIf.w_we), 32'd0);
        check({tag, ".wa"},      32'(wbIf.w_wa), 32'd0);
        check({tag, ".wd"},      wbIf.w_wd, 32'd0);
        check({tag, ".pc"},      wbIf.w_pc, 32'd0);
    endtask

    task automatic runLoad(input logic [2:0] ldType, input logic [1:0] addrLo, input logic [31:0] expOn);
        wbIf.m_ld_type = ldType;
        wbIf.m_addr_lo = addrLo;
        tick();
        expRet++;
`ifdef WB_LOAD_EXT_EN
        check($sformatf("load t%0d a%0d", ldType, addrLo), wbIf.w_wd, expOn);
`else
        check($sformatf("load t%0d a%0d", ldType, addrLo), wbIf.w_wd, 32'h80F17F01);
`endif
    endtask

    initial begin
        reset          = 1'b1;
        wbIf.stall     = 1'b0;
        wbIf.flush     = 1'b0;
        wbIf.m_valid   = 1'b0;
        wbIf.m_sel     = 2'b00;
        wbIf.m_alu     = 32'd0;
        wbIf.m_mem     = 32'd0;
        wbIf.m_md      = 32'd0;
        wbIf.m_pc      = 32'd0;
        wbIf.m_we      = 1'b0;
        wbIf.m_wa      = 5'd0;
        wbIf.m_addr_lo = 2'd0;
        wbIf.m_ld_type = 3'd0;

        // Reset state
        tick();
        tick();
        checkAllZero("reset");
        check("reset.retired", wbIf.w_retired, 32'd0);
        reset = 1'b0;

        // Source select
        wbIf.m_valid = 1'b1;
        wbIf.m_we    = 1'b1;
        wbIf.m_wa    = 5'd5;
        wbIf.m_alu   = 32'h11;
        wbIf.m_mem   = 32'h22;
        wbIf.m_pc    = 32'h00003000;
        wbIf.m_md    = 32'h44;
        for (int s = 0; s < 4; s++) begin
            logic [31:0] expSel [4];
            expSel[0] = 32'h11;
            expSel[1] = 32'h22;
            expSel[2] = 32'h00003008;
            expSel[3] = 32'h44;
            wbIf.m_sel = 2'(s);
            tick();
            expRet++;
            check($sformatf("sel%0d.wd", s), wbIf.w_wd, expSel[s]);
        end
        check("sel.we", 32'(wbIf.w_we), 32'd1);
        check("sel.wa", 32'(wbIf.w_wa), 32'd5);
        check("sel.pc", wbIf.w_pc, 32'h00003000);
        check("sel.valid", 32'(wbIf.w_valid), 32'd1);
        check("sel.retired", wbIf.w_retired, expRet);

        // PC+8 wrap
        wbIf.m_sel = 2'b10;
        wbIf.m_pc  = 32'hFFFFFFFC;
        tick();
        expRet++;
        check("pc8wrap.wd", wbIf.w_wd, 32'h00000004);

        // Load extension
        wbIf.m_sel = 2'b01;
        wbIf.m_mem = 32'h80F17F01;
        runLoad(3'b001, 2'd3, 32'hFFFFFF80);
        runLoad(3'b010, 2'd3, 32'h00000080);
        runLoad(3'b011, 2'd2, 32'hFFFF80F1);
        runLoad(3'b100, 2'd0, 32'h00007F01);
        runLoad(3'b001, 2'd1, 32'h0000007F);
        runLoad(3'b010, 2'd2, 32'h000000F1);
        runLoad(3'b011, 2'd1, 32'h00007F01);
        runLoad(3'b100, 2'd3, 32'h000080F1);
        runLoad(3'b000, 2'd1, 32'h80F17F01);
        runLoad(3'b111, 2'd3, 32'h80F17F01);
        check("load.retired", wbIf.w_retired, expRet);
        wbIf.m_ld_type = 3'd0;
        wbIf.m_addr_lo = 2'd0;

        // Write to $0: no write enable but the instruction retires
        wbIf.m_sel = 2'b00;
        wbIf.m_wa  = 5'd0;
        tick();
        expRet++;
        check("r0.we", 32'(wbIf.w_we), 32'd0);
        check("r0.valid", 32'(wbIf.w_valid), 32'd1);
        check("r0.retired", wbIf.w_retired, expRet);

        // Bubble: no write enable, counter holds
        wbIf.m_wa    = 5'd9;
        wbIf.m_valid = 1'b0;
        tick();
        check("bubble.we", 32'(wbIf.w_we), 32'd0);
        check("bubble.valid", 32'(wbIf.w_valid), 32'd0);
        check("bubble.retired", wbIf.w_retired, expRet);

        // Stall for 3 cycles holds everything
        wbIf.m_valid = 1'b1;
        wbIf.m_wa    = 5'd7;
        wbIf.m_alu   = 32'h1234;
        wbIf.m_pc    = 32'h00004000;
        tick();
        expRet++;
        wbIf.stall = 1'b1;
        wbIf.m_wa  = 5'd8;
        wbIf.m_alu = 32'h5678;
        wbIf.m_pc  = 32'h00004004;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d.wd", i), wbIf.w_wd, 32'h1234);
            check($sformatf("stall%0d.wa", i), 32'(wbIf.w_wa), 32'd7);
            check($sformatf("stall%0d.pc", i), wbIf.w_pc, 32'h00004000);
            check($sformatf("stall%0d.retired", i), wbIf.w_retired, expRet);
        end
        wbIf.stall = 1'b0;
        tick();
        expRet++;
        check("unstall.wd", wbIf.w_wd, 32'h5678);
        check("unstall.wa", 32'(wbIf.w_wa), 32'd8);
        check("unstall.retired", wbIf.w_retired, expRet);

        // Stall and flush together: bubble wins, counter holds
        wbIf.stall = 1'b1;
        wbIf.flush = 1'b1;
        tick();
        checkAllZero("flushstall");
        check("flushstall.retired", wbIf.w_retired, expRet);
        wbIf.stall = 1'b0;
        wbIf.flush = 1'b0;

        // Reset between edges while w_we=1
        wbIf.m_wa  = 5'd3;
        wbIf.m_alu = 32'hCAFE;
        tick();
        expRet++;
        check("prereset.we", 32'(wbIf.w_we), 32'd1);
        check("prereset.retired", wbIf.w_retired, expRet);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("asyncreset");
        check("asyncreset.retired", wbIf.w_retired, 32'd0);
        #1;
        reset = 1'b0;
        expRet = 32'd0;
        tick();
        expRet++;
        check("postreset.wd", wbIf.w_wd, 32'hCAFE);
        check("postreset.retired", wbIf.w_retired, expRet);

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule
